// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/long/repeat pulses,
// plus a held flag and a wrapping press counter.
module button_event_decoder #(
  parameter int LONG_COUNT   = 6000000,
  parameter int REPEAT_COUNT = 1200000,
  parameter int CNT_W        = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  logic level_q, armed_q, rise, fall;
  logic press_q, press_d, release_q, release_d, click_q, click_d;
  logic long_q, long_d, repeat_q, repeat_d;
  always_comb begin
    rise      = armed_q & btn_level & ~level_q;
    fall      = armed_q & ~btn_level & level_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        press_d = 1'b1;
        count_d = count_q + 8'd1;
        cnt_d   = '0;
        state_d = PRESSED;
      end
      PRESSED: if (fall) begin
        release_d = 1'b1;
        click_d   = 1'b1;
        state_d   = IDLE;
      end else if (cnt_q == LONG_LAST) begin
        long_d  = 1'b1;
        cnt_d   = '0;
        state_d = LONG_HELD;
      end else cnt_d = cnt_q + CNT_W'(1);
      LONG_HELD: if (fall) begin
        release_d = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else if (!repeat_en) cnt_d = '0;
      else if (cnt_q == REP_LAST) begin
        repeat_d = 1'b1;
        cnt_d    = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  // Until armed, level_q only captures the current level so a button held through reset never counts as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      level_q   <= 1'b0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      level_q   <= btn_level;
      armed_q   <= 1'b1;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = state_q != IDLE;
  assign press_count   = count_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed checks of the button event decoder with LONG_COUNT=10, REPEAT_COUNT=4.
module tb_button_event_decoder;
  logic clk = 1'b0, reset = 1'b0, btn_level = 1'b1, repeat_en = 1'b0;
  logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;
  logic [4:0] pv;
  int n_cmp = 0, n_err = 0;
  localparam logic [4:0] P_NONE = 5'b00000, P_PRESS = 5'b10000, P_CLICK = 5'b01100;
  localparam logic [4:0] P_REL = 5'b01000, P_LONG = 5'b00010, P_REP = 5'b00001;
  button_event_decoder #(.LONG_COUNT(10), .REPEAT_COUNT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level), .repeat_en(repeat_en),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .click_pulse(click_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held), .press_count(press_count)
  );
  always #5 clk = ~clk;
  assign pv = {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [4:0] ep, input logic eh, input int ec);
    chk({tag, ".pulses"}, int'(pv), int'(ep));
    chk({tag, ".held"}, int'(held), int'(eh));
    chk({tag, ".count"}, int'(press_count), ec);
  endtask
  initial begin
    #23;
    chk_all("reset", P_NONE, 1'b0, 0);
    reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk_all($sformatf("held_thru_reset%0d", i), P_NONE, 1'b0, 0);
    end
    btn_level = 1'b0;
    tick();
    chk_all("rel_after_hold1", P_NONE, 1'b0, 0);
    tick();
    chk_all("rel_after_hold2", P_NONE, 1'b0, 0);
    btn_level = 1'b1;
    tick();
    chk_all("first_press", P_PRESS, 1'b1, 1);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) btn_level = 1'b0;
      tick();
      chk_all($sformatf("short%0d", i), i == 5 ? P_CLICK : P_NONE, i != 5, 1);
    end
    tick();
    chk_all("short_idle", P_NONE, 1'b0, 1);
    repeat_en = 1'b1;
    btn_level = 1'b1;
    tick();
    chk_all("long_press", P_PRESS, 1'b1, 2);
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) btn_level = 1'b0;
      tick();
      chk_all($sformatf("long%0d", i),
              i == 10 ? P_LONG : (i == 14 || i == 18) ? P_REP : i == 20 ? P_REL : P_NONE, i != 20, 2);
    end
    tick();
    btn_level = 1'b1;
    tick();
    chk_all("tie_press", P_PRESS, 1'b1, 3);
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) btn_level = 1'b0;
      tick();
      chk_all($sformatf("tie%0d", i), i == 10 ? P_CLICK : P_NONE, i != 10, 3);
    end
    tick();
    btn_level = 1'b1;
    tick();
    chk_all("en_press", P_PRESS, 1'b1, 4);
    for (int i = 1; i <= 19; i++) begin
      repeat_en = !(i >= 13 && i <= 15);
      tick();
      chk_all($sformatf("en%0d", i), i == 10 ? P_LONG : i == 19 ? P_REP : P_NONE, 1'b1, 4);
    end
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", P_NONE, 1'b0, 0);
    #1 reset = 1'b1;
    btn_level = 1'b0;
    tick();
    tick();
    for (int p = 1; p <= 257; p++) begin
      btn_level = 1'b1;
      tick();
      chk($sformatf("wrap_press%0d", p), int'(pv), int'(P_PRESS));
      chk($sformatf("wrap_count%0d", p), int'(press_count), p % 256);
      btn_level = 1'b0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
